// File: rtl/param_shift_reg_display.sv
// Shift/rotate register with parallel load and a debounced single-step key.
// Drives the LEDs directly and a registered hex seven-segment bus.
`timescale 1ns/1ps
module param_shift_reg_display #(
  parameter int WIDTH           = 10,
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    RST,
  input  logic                    KEY_STEP,
  input  logic                    SW_DIN,
  input  logic [1:0]              MODE,
  input  logic                    LOAD,
  input  logic [WIDTH-1:0]        PDATA,
  output logic [WIDTH-1:0]        LEDR,
  output logic [NUM_DIGITS*8-1:0] HEX,
  output logic [7:0]              STEP_CNT
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Digits that overlap the register; the rest are permanently blank.
  localparam int NUM_ACTIVE = ((WIDTH + 3) / 4 < NUM_DIGITS) ? (WIDTH + 3) / 4 : NUM_DIGITS;
  localparam int EW = 4 * NUM_ACTIVE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_PRESS,
    S_PRESSED,
    S_WAIT_RELEASE
  } state_t;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
    endcase
  endfunction

  function automatic logic [NUM_DIGITS*8-1:0] hex_reset_value();
    logic [NUM_DIGITS*8-1:0] v;
    v = '1;
    for (int d = 0; d < NUM_DIGITS; d++)
      if (4 * d < WIDTH) v[8*d +: 8] = 8'hC0;
    return v;
  endfunction

  localparam logic [NUM_DIGITS*8-1:0] HEX_RST = hex_reset_value();

  logic                    r_sync1, r_sync2;
  state_t                  r_state, w_state_next;
  logic [CW-1:0]           r_cnt, w_cnt_next;
  logic                    r_step, w_step_next;
  logic [WIDTH-1:0]        r_reg;
  logic [7:0]              r_step_cnt;
  logic [NUM_DIGITS*8-1:0] r_hex, w_hex_next;
  logic [EW-1:0]           w_ext;

  // Synchronisers idle high so a released key is not seen as a press out of reset.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep the two flops as a true two-stage chain.
      r_sync1 <= KEY_STEP;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_step  <= w_step_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_step_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_sync2) begin
          w_state_next = S_WAIT_PRESS;
          w_cnt_next   = '0;
        end
      end
      S_WAIT_PRESS: begin
        if (r_sync2)                 w_state_next = S_IDLE;
        else if (r_cnt == CNT_LAST) begin
          w_state_next = S_PRESSED;
          w_step_next  = 1'b1;
        end else                     w_cnt_next = r_cnt + 1'b1;
      end
      S_PRESSED: begin
        if (r_sync2) begin
          w_state_next = S_WAIT_RELEASE;
          w_cnt_next   = '0;
        end
      end
      S_WAIT_RELEASE: begin
        if (!r_sync2)                w_state_next = S_PRESSED;
        else if (r_cnt == CNT_LAST)  w_state_next = S_IDLE;
        else                         w_cnt_next = r_cnt + 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A load wins over a coincident step; that step is lost and not counted.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_reg      <= '0;
      r_step_cnt <= '0;
    end else if (LOAD) begin
      r_reg <= PDATA;
    end else if (r_step) begin
      case (MODE)
        2'b00:   r_reg <= {r_reg[WIDTH-2:0], SW_DIN};
        2'b01:   r_reg <= {SW_DIN, r_reg[WIDTH-1:1]};
        2'b10:   r_reg <= {r_reg[WIDTH-2:0], r_reg[WIDTH-1]};
        default: r_reg <= {r_reg[0], r_reg[WIDTH-1:1]};
      endcase
      r_step_cnt <= r_step_cnt + 8'd1;
    end
  end

  for (genvar j = 0; j < EW; j++) begin : g_ext
    if (j < WIDTH) begin : g_bit
      assign w_ext[j] = r_reg[j];
    end else begin : g_pad
      assign w_ext[j] = 1'b0;
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    if (d < NUM_ACTIVE) begin : g_on
      assign w_hex_next[8*d +: 8] = seg7(w_ext[4*d +: 4]);
    end else begin : g_blank
      assign w_hex_next[8*d +: 8] = 8'hFF;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) r_hex <= HEX_RST;
    else     r_hex <= w_hex_next;
  end

  assign LEDR     = r_reg;
  assign HEX      = r_hex;
  assign STEP_CNT = r_step_cnt;

endmodule

// File: tb/tb_param_shift_reg_display.sv
// Scoreboard bench for param_shift_reg_display: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_param_shift_reg_display;

  localparam int WIDTH = 10;
  localparam int NUM_DIGITS = 4;
  localparam int DEB = 4;

  logic             clk = 1'b0;
  logic             rst, key, sw, load;
  logic [1:0]       mode;
  logic [WIDTH-1:0] pdata, ledr;
  logic [31:0]      hex;
  logic [7:0]       step_cnt;

  typedef struct {
    int          cyc;
    string       name;
    logic [9:0]  ledr;
    logic [7:0]  cnt;
    logic [31:0] hex;
    bit          chk_hex;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_shift_reg_display #(
    .WIDTH(WIDTH), .NUM_DIGITS(NUM_DIGITS), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLOCK_50(clk), .RST(rst), .KEY_STEP(key), .SW_DIN(sw), .MODE(mode),
    .LOAD(load), .PDATA(pdata), .LEDR(ledr), .HEX(hex), .STEP_CNT(step_cnt)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c, input string nm, input logic [9:0] l,
                           input logic [7:0] k, input logic [31:0] h, input bit ch);
    exp_t e;
    e.cyc = c; e.name = nm; e.ledr = l; e.cnt = k; e.hex = h; e.chk_hex = ch;
    sb.push_back(e);
  endtask

  task automatic check(input exp_t e);
    n_vec++;
    if (e.cyc < cyc) begin
      n_miss++;
      $display("FAIL %s: compared at cycle %0d, required at cycle %0d", e.name, cyc, e.cyc);
    end else if (ledr !== e.ledr || step_cnt !== e.cnt || (e.chk_hex && hex !== e.hex)) begin
      n_miss++;
      $display("FAIL %s: got LEDR=%h STEP_CNT=%0d HEX=%h, want LEDR=%h STEP_CNT=%0d HEX=%h (hex checked=%0d)",
               e.name, ledr, step_cnt, hex, e.ledr, e.cnt, e.hex, e.chk_hex);
    end
  endtask

  always @(negedge clk)
    while (sb.size() > 0 && sb[0].cyc <= cyc) check(sb.pop_front());

  initial begin
    rst = 1'b1; key = 1'b1; sw = 1'b0; load = 1'b0; mode = 2'b00; pdata = '0;

    // Reset state, during and just after reset.
    tick(1);
    expect_at(cyc, "reset_hold", 10'h000, 8'd0, 32'hFFC0C0C0, 1'b1);
    tick(2);
    rst = 1'b0;
    t = cyc;
    expect_at(t + 1, "after_reset", 10'h000, 8'd0, 32'hFFC0C0C0, 1'b1);
    tick(2);

    // Parallel load; HEX follows one cycle later.
    load = 1'b1; pdata = 10'h2A5; t = cyc;
    expect_at(t + 1, "load_ledr", 10'h2A5, 8'd0, 32'hFFC0C0C0, 1'b1);
    expect_at(t + 2, "load_hex",  10'h2A5, 8'd0, 32'hFFA48892, 1'b1);
    tick(1); load = 1'b0; tick(3);

    // Long press, shift left with SW_DIN=1: applied on the 8th edge only.
    mode = 2'b00; sw = 1'b1; key = 1'b0; t = cyc;
    expect_at(t + 7, "step_edge7", 10'h2A5, 8'd0, 32'hFFA48892, 1'b1);
    expect_at(t + 8, "step_edge8", 10'h14B, 8'd1, 32'h0, 1'b0);
    expect_at(t + 9, "step_hex",   10'h14B, 8'd1, 32'hFFF99983, 1'b1);
    tick(20); key = 1'b1; tick(12);
    expect_at(cyc + 1, "held_one_step", 10'h14B, 8'd1, 32'hFFF99983, 1'b1);
    tick(2);

    // Bouncing key never accepted.
    key = 1'b0; tick(2); key = 1'b1; tick(1); key = 1'b0; tick(2); key = 1'b1; tick(15);
    expect_at(cyc + 1, "bounce_nostep", 10'h14B, 8'd1, 32'hFFF99983, 1'b1);
    tick(2);

    // Rotate right then rotate left.
    load = 1'b1; pdata = 10'h001; tick(1); load = 1'b0; mode = 2'b11; sw = 1'b0; tick(2);
    key = 1'b0; t = cyc;
    expect_at(t + 8, "rotate_right", 10'h200, 8'd2, 32'h0, 1'b0);
    tick(8); key = 1'b1; tick(12);
    mode = 2'b10; key = 1'b0; t = cyc;
    expect_at(t + 8, "rotate_left",     10'h001, 8'd3, 32'h0, 1'b0);
    expect_at(t + 9, "rotate_left_hex", 10'h001, 8'd3, 32'hFFC0C0F9, 1'b1);
    tick(8); key = 1'b1; tick(12);

    // Load coincident with the step pulse: load wins, count unchanged.
    mode = 2'b00; sw = 1'b1; key = 1'b0; t = cyc;
    tick(7);
    load = 1'b1; pdata = 10'h3FF;
    expect_at(t + 8, "load_beats_step",     10'h3FF, 8'd3, 32'h0, 1'b0);
    expect_at(t + 9, "load_beats_step_hex", 10'h3FF, 8'd3, 32'hFFB08E8E, 1'b1);
    tick(1); load = 1'b0; tick(1); key = 1'b1; tick(12);
    expect_at(cyc + 1, "no_late_step", 10'h3FF, 8'd3, 32'hFFB08E8E, 1'b1);
    tick(2);

    // Reset while in WAIT_PRESS, key released shortly after reset.
    key = 1'b0; tick(4);
    rst = 1'b1; t = cyc;
    expect_at(t, "async_reset", 10'h000, 8'd0, 32'hFFC0C0C0, 1'b1);
    tick(2); rst = 1'b0; tick(2); key = 1'b1; tick(15);
    expect_at(cyc + 1, "reset_midpress", 10'h000, 8'd0, 32'hFFC0C0C0, 1'b1);
    tick(2);

    // 256 presses: counter reaches 255 then wraps to 0.
    sw = 1'b0; mode = 2'b00;
    for (int i = 1; i <= 256; i++) begin
      key = 1'b0; t = cyc;
      if (i == 255) expect_at(t + 8, "cnt_255",  10'h000, 8'd255, 32'h0, 1'b0);
      if (i == 256) expect_at(t + 8, "cnt_wrap", 10'h000, 8'd0,   32'h0, 1'b0);
      tick(8); key = 1'b1; tick(12);
    end

    for (int i = 0; i < 100 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_drain: %0d expectations pending, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/param_shift_reg_display.md
Name: param_shift_reg_display

Overview:
Parametrised successor to the board-level shift-register/display block. It provides a WIDTH-bit register with four shift/rotate modes, a synchronous parallel load, and a debounced single-step pushbutton. The register drives the LEDs directly and a NUM_DIGITS hex seven-segment bus, and an 8-bit step counter reports applied shifts. It sits between the board I/O (CLOCK_50, keys, switches) and the LED/HEX pins.

Parameters:
WIDTH, 10, register width in bits (legal 2..32)
NUM_DIGITS, 4, number of 7-segment digits driven (legal 1..8)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a press or release (legal >=1)

Ports:
CLOCK_50  in  1  system clock, all state on its rising edge
RST  in  1  asynchronous, active-high reset
KEY_STEP  in  1  active-low pushbutton (0 = pressed), asynchronous to CLOCK_50
SW_DIN  in  1  serial data in from a switch, quasi-static
MODE  in  2  00 shift left, 01 shift right, 10 rotate left, 11 rotate right
LOAD  in  1  synchronous parallel-load strobe, active-high
PDATA  in  WIDTH  parallel load value
LEDR  out  WIDTH  current register value
HEX  out  NUM_DIGITS*8  digit i at bits [8i+7:8i], active-low, bit7 = dp, bits6:0 = g..a
STEP_CNT  out  8  count of applied step shifts

Behaviour:
- Reset (RST=1, asynchronous): register=0, LEDR=0, STEP_CNT=0, sync flops=1, FSM=IDLE, debounce count=0, step pulse=0. HEX = 8'hC0 ("0") for active digits and 8'hFF for blank digits.
- KEY_STEP passes through a 2-flop synchroniser (s2 = synchronised level).
- Debounce FSM, count cnt:
  - IDLE: if s2=0, go to WAIT_PRESS with cnt=0.
  - WAIT_PRESS: if s2=1, go to IDLE. Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED and set step=1 for exactly one cycle. Else cnt++.
  - PRESSED: if s2=1, go to WAIT_RELEASE with cnt=0.
  - WAIT_RELEASE: if s2=0, go to PRESSED with no new step. Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE. Else cnt++.
- Exactly one step is generated per accepted press, however long the key is held.
- Step latency: the register updates on the (DEBOUNCE_CYCLES+4)th rising edge, counting the first edge that samples KEY_STEP=0.
- Register update priority, evaluated each edge:
  1. LOAD=1: reg <= PDATA. A coincident step is discarded and STEP_CNT is unchanged.
  2. Step=1:
     - 00: reg <= {reg[W-2:0], SW_DIN}
     - 01: reg <= {SW_DIN, reg[W-1:1]}
     - 10: reg <= {reg[W-2:0], reg[W-1]}
     - 11: reg <= {reg[0], reg[W-1:1]}
     - STEP_CNT increments, wrapping 255 -> 0.
  3. Otherwise: hold.
- MODE and SW_DIN are sampled on the edge that applies the step.
- LEDR is driven from the register, with zero added latency.
- HEX is registered, one cycle behind LEDR:
  - Digit i shows nibble reg[4i+3:4i], with bits above WIDTH read as 0.
  - A digit is blank (8'hFF) when 4i >= WIDTH.
  - dp is always off (1).
- Seven-segment codes 0-F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- LOAD does not clear STEP_CNT or affect the debounce FSM.
- RST mid-press: the FSM returns to IDLE. If the key is still held after reset, it is treated as a fresh press and debounced again from scratch.

Test Plan (WIDTH=10, NUM_DIGITS=4, DEBOUNCE_CYCLES=4):
1. Assert RST, release; KEY_STEP=1 -> LEDR=10'h000, STEP_CNT=0, HEX=32'hFFC0C0C0.
2. LOAD=1 for one cycle with PDATA=10'h2A5 -> LEDR=10'h2A5 next edge; one edge later HEX=32'hFFA48892.
3. MODE=00, SW_DIN=1, KEY_STEP low for 20 cycles then high -> exactly one shift on the 8th edge: LEDR=10'h14B, STEP_CNT=1.
4. Bounce: KEY_STEP low 2 cycles, high 1, low 2, then high -> LEDR and STEP_CNT unchanged.
5. LOAD 10'h001, MODE=11, one clean press -> LEDR=10'h200. Then MODE=10, another press -> LEDR=10'h001. STEP_CNT increases by 2.
6. Step pulse coincides with LOAD=1, PDATA=10'h3FF -> LEDR=10'h3FF, STEP_CNT unchanged. Separately, RST pulsed in WAIT_PRESS with the key released within 3 cycles after reset -> no shift, LEDR=0.
